// File: rtl/axi_lite_sim_memory.sv
// -----------------------------------------------------------------------------
// axi_lite_sim_memory
//
// Simulation AXI4-Lite slave memory. It holds DEPTH_WORDS words of DATA_WIDTH
// bits and uses byte addressing. Read and write latency can be set per channel.
// Each channel allows one transaction in flight. Writes honour byte strobes.
// An access whose word index is past the end of the memory gets an SLVERR
// response.
//
// Ports:
//   aclk, areset            clock, synchronous active-high reset
//   araddr/arprot/arvalid   read address channel (arprot ignored), arready out
//   rdata/rresp/rvalid      read data channel, rready in
//   awaddr/awprot/awvalid   write address channel (awprot ignored), awready out
//   wdata/wstrb/wvalid      write data channel, wready out
//   bresp/bvalid            write response channel, bready in
// -----------------------------------------------------------------------------
module axi_lite_sim_memory #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH_WORDS   = 4096,
    parameter int READ_LATENCY  = 30,
    parameter int WRITE_LATENCY = 0
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [2:0]              arprot,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rvalid,
    input  logic                    rready,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [2:0]              awprot,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready
);

    localparam int          STRB_W   = DATA_WIDTH / 8;
    localparam int          OFFSET_W = $clog2(STRB_W);
    localparam int          IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RD_LAT   = 32'(READ_LATENCY);
    localparam logic [31:0] WR_LAT   = 32'(WRITE_LATENCY);

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

    // The memory is not reset. It starts at zero at time 0.
    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS] = '{default: '0};

    r_state_t          r_state;
    logic [31:0]       r_count;
    logic [IDX_W-1:0]  r_idx;
    logic              r_oob;

    w_state_t          w_state;
    logic [31:0]       w_count;
    logic [IDX_W-1:0]  w_idx;
    logic              w_oob;
    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_W-1:0] w_strb;
    logic              aw_done;
    logic              w_done;
    logic              w_commit;

    logic unused_prot;
    assign unused_prot = ^{arprot, awprot};

    // Byte offset bits are dropped. Higher bits select the word.
    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
        return addr[OFFSET_W +: IDX_W];
    endfunction

    // Any set bit above the index field means index >= DEPTH_WORDS.
    function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] hi;
        hi = addr >> (OFFSET_W + IDX_W);
        return |hi;
    endfunction

    // ---------------- read channel ----------------
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= R_IDLE;
            r_count <= '0;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= 2'b00;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (arvalid && arready) begin
                        r_idx   <= word_idx(araddr);
                        r_oob   <= out_of_range(araddr);
                        arready <= 1'b0;
                        r_count <= '0;
                        r_state <= R_WAIT;
                    end else begin
                        arready <= 1'b1;
                    end
                end
                R_WAIT: begin
                    if (r_count == RD_LAT) begin
                        // A write committing on this same edge is not seen yet.
                        rdata   <= r_oob ? '0 : mem[r_idx];
                        rresp   <= r_oob ? 2'b10 : 2'b00;
                        rvalid  <= 1'b1;
                        r_state <= R_RESP;
                    end else begin
                        r_count <= r_count + 32'd1;
                    end
                end
                R_RESP: begin
                    if (rready) begin
                        rvalid  <= 1'b0;
                        arready <= 1'b1;
                        r_state <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // ---------------- write channel ----------------
    // AW and W are captured independently. The wait starts once both are held.
    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state <= W_IDLE;
            w_count <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= 2'b00;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (awvalid && awready) begin
                        w_idx   <= word_idx(awaddr);
                        w_oob   <= out_of_range(awaddr);
                        aw_done <= 1'b1;
                        awready <= 1'b0;
                    end else if (!aw_done) begin
                        awready <= 1'b1;
                    end
                    if (wvalid && wready) begin
                        w_data <= wdata;
                        w_strb <= wstrb;
                        w_done <= 1'b1;
                        wready <= 1'b0;
                    end else if (!w_done) begin
                        wready <= 1'b1;
                    end
                    if ((aw_done || (awvalid && awready)) && (w_done || (wvalid && wready))) begin
                        w_count <= '0;
                        w_state <= W_WAIT;
                    end
                end
                W_WAIT: begin
                    if (w_count == WR_LAT) begin
                        bresp   <= w_oob ? 2'b10 : 2'b00;
                        bvalid  <= 1'b1;
                        w_state <= W_RESP;
                    end else begin
                        w_count <= w_count + 32'd1;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        awready <= 1'b1;
                        wready  <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Commit happens on the same edge that raises bvalid.
    assign w_commit = !areset && (w_state == W_WAIT) && (w_count == WR_LAT) && !w_oob;

    always_ff @(posedge aclk) begin
        if (w_commit) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (w_strb[b]) begin
                    mem[w_idx][8*b +: 8] <= w_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_sim_memory.sv
module tb_axi_lite_sim_memory;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [31:0] araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b1;
    logic [31:0] awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b1;

    int checks = 0;
    int errors = 0;

    logic [33:0] rd_q[$];   // {rresp, rdata}
    logic [1:0]  b_q[$];

    always #5 aclk = ~aclk;

    axi_lite_sim_memory dut (
        .aclk(aclk), .areset(areset),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic send_ar(input logic [31:0] addr);
        araddr  = addr;
        arvalid = 1'b1;
        for (int i = 0; i < 100 && !arready; i++) @(negedge aclk);
        checks++;
        if (arready !== 1'b1) begin
            errors++;
            $display("FAIL ar_handshake: arready=%b required 1", arready);
        end
        @(negedge aclk);
        arvalid = 1'b0;
    endtask

    task automatic send_aw(input logic [31:0] addr);
        awaddr  = addr;
        awvalid = 1'b1;
        for (int i = 0; i < 100 && !awready; i++) @(negedge aclk);
        checks++;
        if (awready !== 1'b1) begin
            errors++;
            $display("FAIL aw_handshake: awready=%b required 1", awready);
        end
        @(negedge aclk);
        awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
        wdata  = data;
        wstrb  = strb;
        wvalid = 1'b1;
        for (int i = 0; i < 100 && !wready; i++) @(negedge aclk);
        checks++;
        if (wready !== 1'b1) begin
            errors++;
            $display("FAIL w_handshake: wready=%b required 1", wready);
        end
        @(negedge aclk);
        wvalid = 1'b0;
    endtask

    // Waits for rvalid, then compares against the scoreboard head.
    task automatic wait_r(output int lat);
        logic [33:0] exp;
        lat = 0;
        while (rvalid !== 1'b1 && lat < 200) begin
            @(negedge aclk);
            lat++;
        end
        exp = rd_q.pop_front();
        checks++;
        if (rvalid !== 1'b1) begin
            errors++;
            $display("FAIL r_timeout: rvalid=%b required 1 within 200 cycles", rvalid);
        end
        checks++;
        if (rdata !== exp[31:0]) begin
            errors++;
            $display("FAIL rdata: got %h required %h", rdata, exp[31:0]);
        end
        checks++;
        if (rresp !== exp[33:32]) begin
            errors++;
            $display("FAIL rresp: got %b required %b", rresp, exp[33:32]);
        end
    endtask

    task automatic wait_b();
        logic [1:0] exp;
        int n = 0;
        while (bvalid !== 1'b1 && n < 200) begin
            @(negedge aclk);
            n++;
        end
        exp = b_q.pop_front();
        checks++;
        if (bvalid !== 1'b1) begin
            errors++;
            $display("FAIL b_timeout: bvalid=%b required 1 within 200 cycles", bvalid);
        end
        checks++;
        if (bresp !== exp) begin
            errors++;
            $display("FAIL bresp: got %b required %b", bresp, exp);
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp, input bit check_lat);
        int lat;
        rd_q.push_back({exp_resp, exp_data});
        send_ar(addr);
        wait_r(lat);
        if (check_lat) begin
            checks++;
            if (lat != 31) begin
                errors++;
                $display("FAIL read_latency: rvalid after %0d cycles required 31", lat);
            end
        end
        @(negedge aclk);
        checks++;
        if (rvalid !== 1'b0 || arready !== 1'b1) begin
            errors++;
            $display("FAIL r_release: rvalid=%b arready=%b required 0/1", rvalid, arready);
        end
    endtask

    // w_lead = 0 presents AW and W together. Otherwise W leads AW by w_lead cycles.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int w_lead, input logic [1:0] exp_resp);
        b_q.push_back(exp_resp);
        if (w_lead == 0) begin
            fork
                send_aw(addr);
                send_w(data, strb);
            join
        end else begin
            send_w(data, strb);
            for (int i = 1; i < w_lead; i++) @(negedge aclk);
            checks++;
            if (bvalid !== 1'b0 || wready !== 1'b0 || awready !== 1'b1) begin
                errors++;
                $display("FAIL w_only_hold: bvalid=%b wready=%b awready=%b required 0/0/1",
                         bvalid, wready, awready);
            end
            send_aw(addr);
        end
        wait_b();
        @(negedge aclk);
        checks++;
        if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin
            errors++;
            $display("FAIL b_release: bvalid=%b awready=%b wready=%b required 0/1/1",
                     bvalid, awready, wready);
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (2) @(negedge aclk);
        checks++;
        if ({arready, awready, wready, rvalid, bvalid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ar/aw/w/rv/bv=%b required 00000",
                     {arready, awready, wready, rvalid, bvalid});
        end
        checks++;
        if (rdata !== 32'h0 || rresp !== 2'b00 || bresp !== 2'b00) begin
            errors++;
            $display("FAIL reset_data: rdata=%h rresp=%b bresp=%b required 0", rdata, rresp, bresp);
        end
        areset = 1'b0;
        @(negedge aclk);
        checks++;
        if ({arready, awready, wready, rvalid, bvalid} !== 5'b11100) begin
            errors++;
            $display("FAIL idle_after_reset: ar/aw/w/rv/bv=%b required 11100",
                     {arready, awready, wready, rvalid, bvalid});
        end
    endtask

    task automatic test_write_read();
        do_write(32'h100, 32'hDEADBEEF, 4'hF, 0, 2'b00);
        do_read(32'h100, 32'hDEADBEEF, 2'b00, 1'b1);
    endtask

    task automatic test_strobes();
        do_write(32'h100, 32'h11223344, 4'b0101, 2, 2'b00);
        do_read(32'h100, 32'hDE22BE44, 2'b00, 1'b0);
        do_write(32'h100, 32'hFFFFFFFF, 4'b0000, 0, 2'b00);
        do_read(32'h103, 32'hDE22BE44, 2'b00, 1'b0);
        do_write(32'h102, 32'hA5A5A5A5, 4'b1000, 0, 2'b00);
        do_read(32'h100, 32'hA522BE44, 2'b00, 1'b0);
    endtask

    task automatic test_backpressure();
        int lat;
        logic [31:0] hold_d;
        logic [1:0]  hold_r;
        rready = 1'b0;
        rd_q.push_back({2'b00, 32'hA522BE44});
        send_ar(32'h100);
        wait_r(lat);
        hold_d = rdata;
        hold_r = rresp;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            checks++;
            if (rvalid !== 1'b1 || rdata !== hold_d || rresp !== hold_r || arready !== 1'b0) begin
                errors++;
                $display("FAIL r_stall: rvalid=%b rdata=%h rresp=%b arready=%b required 1/%h/%b/0",
                         rvalid, rdata, rresp, arready, hold_d, hold_r);
            end
        end
        rready = 1'b1;
        @(negedge aclk);
        checks++;
        if (rvalid !== 1'b0 || arready !== 1'b1) begin
            errors++;
            $display("FAIL r_stall_release: rvalid=%b arready=%b required 0/1", rvalid, arready);
        end

        bready = 1'b0;
        b_q.push_back(2'b00);
        fork
            send_aw(32'h300);
            send_w(32'hCAFEF00D, 4'hF);
        join
        wait_b();
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            checks++;
            if (bvalid !== 1'b1 || awready !== 1'b0 || wready !== 1'b0) begin
                errors++;
                $display("FAIL b_stall: bvalid=%b awready=%b wready=%b required 1/0/0",
                         bvalid, awready, wready);
            end
        end
        bready = 1'b1;
        @(negedge aclk);
        checks++;
        if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin
            errors++;
            $display("FAIL b_stall_release: bvalid=%b awready=%b wready=%b required 0/1/1",
                     bvalid, awready, wready);
        end
        do_read(32'h300, 32'hCAFEF00D, 2'b00, 1'b0);
    endtask

    task automatic test_out_of_range();
        do_read(32'h4000, 32'h0, 2'b10, 1'b0);
        do_write(32'h4000, 32'hFFFFFFFF, 4'hF, 0, 2'b10);
        do_read(32'h0, 32'h0, 2'b00, 1'b0);
        do_read(32'h100, 32'hA522BE44, 2'b00, 1'b0);
        do_read(32'h300, 32'hCAFEF00D, 2'b00, 1'b0);
    endtask

    task automatic test_reset_mid_read();
        int seen = 0;
        send_ar(32'h0);
        repeat (9) @(negedge aclk);
        areset = 1'b1;
        @(negedge aclk);
        checks++;
        if (arready !== 1'b0 || rvalid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: arready=%b rvalid=%b required 0/0", arready, rvalid);
        end
        areset = 1'b0;
        @(negedge aclk);
        checks++;
        if (arready !== 1'b1) begin
            errors++;
            $display("FAIL arready_after_reset: got %b required 1", arready);
        end
        for (int i = 0; i < 40; i++) begin
            if (rvalid === 1'b1) seen++;
            @(negedge aclk);
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abandoned_read: rvalid high %0d cycles required 0", seen);
        end
        do_read(32'h100, 32'hA522BE44, 2'b00, 1'b1);
    endtask

    task automatic test_concurrent();
        fork
            do_read(32'h300, 32'hCAFEF00D, 2'b00, 1'b1);
            do_write(32'h204, 32'h0BADC0DE, 4'hF, 0, 2'b00);
        join
        do_read(32'h204, 32'h0BADC0DE, 2'b00, 1'b0);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_strobes();
        test_backpressure();
        test_out_of_range();
        test_reset_mid_read();
        test_concurrent();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_lite_sim_memory.md
Name: axi_lite_sim_memory

Overview:
Simulation-only AXI4-Lite slave memory model. It is the parametrised successor of the fixed 4096x32 testbench memory, adding configurable width, depth and per-channel latency. It also adds proper single-outstanding handshakes, byte-strobe writes, byte addressing and SLVERR on out-of-range accesses. It sits behind the core's instruction and data AXI-Lite masters in the simulation top level.

Parameters:
ADDR_WIDTH, 32, width of araddr/awaddr (byte address)
DATA_WIDTH, 32, data bus width; must be 32 or 64
DEPTH_WORDS, 4096, number of DATA_WIDTH words; must be a power of two
READ_LATENCY, 30, wait cycles between AR acceptance and rvalid; 0 allowed
WRITE_LATENCY, 0, wait cycles between AW+W both captured and bvalid; 0 allowed

Ports:
aclk  in  1  clock
areset  in  1  synchronous active-high reset
araddr  in  ADDR_WIDTH  read byte address
arprot  in  3  ignored
arvalid  in  1  read address valid
arready  out  1  read address ready
rdata  out  DATA_WIDTH  read data
rresp  out  2  read response: 2'b00 OKAY, 2'b10 SLVERR
rvalid  out  1  read data valid
rready  in  1  read data ready
awaddr  in  ADDR_WIDTH  write byte address
awprot  in  3  ignored
awvalid  in  1  write address valid
awready  out  1  write address ready
wdata  in  DATA_WIDTH  write data
wstrb  in  DATA_WIDTH/8  byte strobes
wvalid  in  1  write data valid
wready  out  1  write data ready
bresp  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR
bvalid  out  1  write response valid
bready  in  1  write response ready

Behaviour:
- Reset (areset=1 at posedge aclk): all outputs go to 0 (arready, awready, wready, rvalid, bvalid, rdata, rresp, bresp). Both FSMs go to IDLE and counters clear. Reset mid-transaction abandons it with no response. Memory contents are not reset; they are zero-initialised at time 0.
- Word index = addr >> log2(DATA_WIDTH/8), with low offset bits ignored. Index >= DEPTH_WORDS is out of range.
- Read FSM, states R_IDLE, R_WAIT, R_RESP:
  - R_IDLE: arready=1 (registered, so it rises the cycle after reset deasserts). A handshake (arvalid&arready) at edge T latches the index, drops arready, and goes to R_WAIT with count=0.
  - R_WAIT: count increments each cycle. When count==READ_LATENCY, memory is sampled into rdata, rresp is set, rvalid=1, and the FSM goes to R_RESP. With READ_LATENCY=0, rvalid is high in the cycle after the handshake; in general rvalid is first high READ_LATENCY+1 cycles after the handshake cycle.
  - R_RESP: rvalid and rdata hold stable until rready. The rvalid&rready edge clears rvalid and returns to R_IDLE (arready=1 next cycle). There is one outstanding read; no back-to-back acceptance in the same cycle as a response.
  - Out-of-range read: rdata=0, rresp=2'b10.
- Write FSM, states W_IDLE, W_WAIT, W_RESP. AW and W are accepted independently, in either order or simultaneously:
  - awready=1 in W_IDLE until AW is captured, then 0.
  - wready=1 in W_IDLE until W (wdata, wstrb) is captured, then 0.
  - Once both are captured, go to W_WAIT. Count to WRITE_LATENCY, then commit the bytes whose wstrb bit is 1. Bytes with wstrb=0 are unchanged; wstrb=0 writes nothing.
  - Set bvalid=1 and enter W_RESP. bvalid holds until bready; the handshake returns to W_IDLE and both readies reassert next cycle.
  - Out-of-range write: no memory change, bresp=2'b10.
- Read/write collision: the read sample and the write commit in the same cycle on the same word means the read returns the pre-write value. A write committed on an earlier edge is visible.
- Read and write channels operate concurrently and independently.
- arprot and awprot are unused.

Test Plan:
- Reset then idle: areset high 2 cycles, then low -> all outputs 0 during reset; arready=awready=wready=1 one cycle after release; rvalid=bvalid=0.
- Write then read, READ_LATENCY=30: AW 0x100 plus W 0xDEADBEEF with wstrb 4'hF in the same cycle, bready=1 -> bvalid pulses with bresp 0. Then AR 0x100 at cycle T -> rvalid first high at T+31 with rdata 0xDEADBEEF and rresp 0.
- Byte strobes with W before AW: W 0x11223344 with wstrb 4'b0101 two cycles before AW 0x100, over prior 0xDEADBEEF -> no commit until AW arrives; a later read returns 0xDE22BE44.
- Backpressure: hold rready=0 for 5 cycles after rvalid -> rvalid, rdata and rresp stay stable and arready stays 0. Hold bready=0 -> bvalid stays high and awready/wready stay 0.
- Out of range: AR 0x4000 and AW 0x4000 with DEPTH_WORDS=4096 -> rresp 2'b10 with rdata 0; bresp 2'b10 with no memory word changed.
- Reset mid-read: AR 0x0, then areset at count 10 -> rvalid never asserts, and arready is 1 one cycle after release. A new read then completes normally.
